ls_buffer: RTL and testbench
============================

Name: ls_buffer

Overview:
- In-order load/store queue of the Tomasulo core.
- Receives load/store ops from the issuer and snoops the rss and lsb result buses for operands.
- Consumes the ROB commit bus: a dest with ls_select=1 commits a store; ls_select=0 releases the load at the ROB head.
- Drives one memory access at a time and broadcasts load results on the lsb bus.

Parameters:
- LSB_SIZE, 16, number of queue entries (power of 2).
- ROB_ID_W, 4, ROB id width; id 0 means "none".
- REG_W, 32, data/address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- rdy  in  1  global enable; state holds when low.
- is_ls_buffer_full  out  1  size >= LSB_SIZE-1 (pre-full).
- valid_from_issuer  in  1  enqueue strobe.
- op_from_issuer  in  4  LB,LH,LW,LBU,LHU,SB,SH,SW encoding.
- dest_from_issuer  in  ROB_ID_W  ROB id of the op.
- qj_from_issuer / vj_from_issuer  in  ROB_ID_W / REG_W  base tag/value; qj=0 means vj valid.
- qk_from_issuer / vk_from_issuer  in  ROB_ID_W / REG_W  store-data tag/value.
- imm_from_issuer  in  REG_W  sign-extended offset.
- reset_from_rob_bus  in  1  mispredict flush.
- dest_from_rob_bus  in  ROB_ID_W  ROB head id (0 = none).
- ls_select_from_rob_bus  in  1  1 = store commit, 0 = load release.
- dest_from_rss_bus / value_from_rss_bus  in  ROB_ID_W / REG_W  ALU broadcast.
- dest_to_lsb_bus / value_to_lsb_bus  out  ROB_ID_W / REG_W  load-result broadcast; also snooped internally.
- mem_valid  out  1  request; held until mem_done.
- mem_we  out  1  1 = write.
- mem_addr  out  REG_W  byte address.
- mem_wdata  out  REG_W  store data.
- mem_len  out  2  0 = byte, 1 = half, 2 = word.
- mem_done  in  1  one-cycle completion.
- mem_rdata  in  REG_W  raw read data, LSB-aligned.

Behaviour:
- Reset (rst=0, async): head=tail=size=commit_cnt=0, all entries invalid, FSM IDLE, every output 0.
- Enqueue: if valid_from_issuer, write the entry at tail; tail wraps at LSB_SIZE. Same-cycle bus matches on qj/qk capture the value immediately.
- Snoop: every valid entry with qj or qk equal to a nonzero rss or lsb dest takes the value and clears the tag. The lsb bus is the registered output of this block.
- Store commit: dest_from_rob_bus!=0, ls_select=1, matching the first uncommitted entry → set committed, commit_cnt+1.
- Load release: ls_select=0 and dest equals the head entry's dest (head is a load) → load_go. The ROB repeats the id every cycle, so this is idempotent.
- FSM IDLE → ACCESS when the head entry is ready:
  - store: committed and qj=qk=0;
  - load: load_go and qj=0.
  - mem_addr = vj+imm (wraps mod 2^32); mem_len from op; mem_valid=1.
- ACCESS → IDLE on mem_done; the head pops.
  - store: commit_cnt-1; no broadcast.
  - load: next cycle dest_to_lsb_bus=dest; value = LB/LH sign-extended, LBU/LHU zero-extended.
- The broadcast is a one-cycle pulse; otherwise dest_to_lsb_bus=0 and value_to_lsb_bus=0.
- Flush (reset_from_rob_bus=1):
  - keep the first commit_cnt entries (committed stores); tail = head+commit_cnt mod LSB_SIZE; size = commit_cnt.
  - in-flight store keeps going.
  - in-flight load → DRAIN: hold mem_valid until mem_done, discard data, no broadcast, then IDLE.
  - enqueue and load release ignored that cycle.
- size update = size + enqueue − pop, evaluated in the same cycle.
- Full queue: the issuer must not enqueue when full; enqueue while size==LSB_SIZE is undefined.
- Empty queue: FSM stays IDLE.
- rdy=0: freeze all state. The mem request is held; mem_done arriving while rdy=0 is not allowed.

Optional Feature:
- LS_BUFFER_PERF_EN defined: outputs perf_load_cnt[31:0] and perf_store_cnt[31:0].
  - Each increments on a completed load/store mem_done; drained loads are not counted.
  - Zero on reset, wrap at 2^32.
- Not defined: ports and counters are absent.

Decomposition:
- Shared config.v macros: op encodings, ROB id type, LSB_SIZE, mem_len codes, REG_TYPE.
- Sub-module ls_mem_unit holds the IDLE/ACCESS/DRAIN FSM, the load extension and the broadcast register.
- ls_buffer keeps the queue, snoop and commit logic.

Test Plan:
- LW issued with qj=0, vj=0x100, imm=4, dest=3; rob bus dest=3, ls_select=0 → mem_addr=0x104, len=2. mem_done with rdata=0xDEADBEEF → next cycle lsb bus dest=3, value=0xDEADBEEF.
- LB, rdata=0x80 → value 0xFFFFFF80; LBU, same rdata → 0x00000080.
- SW with qk=5: rss bus dest=5, value=0x1234 → after commit of dest 6 (ls_select=1), mem_we=1, wdata=0x1234; no lsb broadcast.
- Committed SW then uncommitted LW queued, then flush → store completes, load discarded, size reaches 0.
- Flush during load ACCESS → mem_valid held until mem_done, no broadcast, next load executes normally.
- Fill to LSB_SIZE-1 with wrap past index 15 → is_ls_buffer_full=1. Drain → entries execute in order and full deasserts.

Source files
------------

// File: rtl/ls_buffer_pkg.sv
// Shared op encodings, memory length codes and FSM states for the load/store buffer.
// The optional perf counters are enabled with LS_BUFFER_PERF_EN.
package ls_buffer_pkg;
    localparam int LSB_SIZE_DEF = 16;
    localparam int ROB_ID_W_DEF = 4;
    localparam int REG_W_DEF    = 32;

    // bit 3 set marks a store
    typedef enum logic [3:0] {
        OP_LB  = 4'h0,
        OP_LH  = 4'h1,
        OP_LW  = 4'h2,
        OP_LBU = 4'h4,
        OP_LHU = 4'h5,
        OP_SB  = 4'h8,
        OP_SH  = 4'h9,
        OP_SW  = 4'hA
    } ls_op_e;

    typedef enum logic [1:0] {
        LEN_BYTE = 2'd0,
        LEN_HALF = 2'd1,
        LEN_WORD = 2'd2
    } mem_len_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DRAIN  = 2'd2
    } mem_state_e;

    function automatic logic op_is_store(input logic [3:0] op);
        return op[3];
    endfunction

    function automatic logic [1:0] op_len(input logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return LEN_BYTE;
            OP_LH, OP_LHU, OP_SH: return LEN_HALF;
            default:              return LEN_WORD;
        endcase
    endfunction
endpackage

// File: rtl/ls_mem_unit.sv
// Single-outstanding memory access engine: IDLE/ACCESS/DRAIN FSM, load extension and lsb
// broadcast register. Perf counters present only with LS_BUFFER_PERF_EN.
module ls_mem_unit
    import ls_buffer_pkg::*;
#(
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int REG_W    = REG_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                flush,
    input  logic                req_valid,
    input  logic [3:0]          req_op,
    input  logic [ROB_ID_W-1:0] req_dest,
    input  logic [REG_W-1:0]    req_addr,
    input  logic [REG_W-1:0]    req_wdata,
    output logic                pop,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [REG_W-1:0]    mem_addr,
    output logic [REG_W-1:0]    mem_wdata,
    output logic [1:0]          mem_len,
    input  logic                mem_done,
    input  logic [REG_W-1:0]    mem_rdata,
    output logic [ROB_ID_W-1:0] bc_dest,
    output logic [REG_W-1:0]    bc_value
`ifdef LS_BUFFER_PERF_EN
    ,
    output logic [31:0]         perf_load_cnt,
    output logic [31:0]         perf_store_cnt
`endif
);
    mem_state_e          state, state_nxt;
    logic [3:0]          op_q;
    logic [ROB_ID_W-1:0] dest_q;
    logic                start, bc_fire, store_done;
    logic [REG_W-1:0]    load_val;

    always_comb begin
        state_nxt  = state;
        start      = 1'b0;
        pop        = 1'b0;
        bc_fire    = 1'b0;
        store_done = 1'b0;
        if (rdy) begin
            case (state)
                ST_IDLE: if (req_valid) begin
                    start     = 1'b1;
                    state_nxt = ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (op_is_store(op_q)) begin
                        // committed stores survive a flush
                        if (mem_done) begin
                            pop        = 1'b1;
                            store_done = 1'b1;
                            state_nxt  = ST_IDLE;
                        end
                    end else if (flush) begin
                        state_nxt = mem_done ? ST_IDLE : ST_DRAIN;
                    end else if (mem_done) begin
                        pop       = 1'b1;
                        bc_fire   = 1'b1;
                        state_nxt = ST_IDLE;
                    end
                end
                ST_DRAIN: if (mem_done) state_nxt = ST_IDLE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        load_val = mem_rdata;
        case (op_q)
            OP_LB:   load_val = {{(REG_W-8){mem_rdata[7]}}, mem_rdata[7:0]};
            OP_LH:   load_val = {{(REG_W-16){mem_rdata[15]}}, mem_rdata[15:0]};
            OP_LBU:  load_val = {{(REG_W-8){1'b0}}, mem_rdata[7:0]};
            OP_LHU:  load_val = {{(REG_W-16){1'b0}}, mem_rdata[15:0]};
            default: load_val = mem_rdata;
        endcase
    end

    assign mem_valid = (state != ST_IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op_q      <= '0;
            dest_q    <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_len   <= '0;
            bc_dest   <= '0;
            bc_value  <= '0;
        end else if (rdy) begin
            state    <= state_nxt;
            bc_dest  <= '0;
            bc_value <= '0;
            if (start) begin
                op_q      <= req_op;
                dest_q    <= req_dest;
                mem_we    <= op_is_store(req_op);
                mem_addr  <= req_addr;
                mem_wdata <= req_wdata;
                mem_len   <= op_len(req_op);
            end
            if (bc_fire) begin
                bc_dest  <= dest_q;
                bc_value <= load_val;
            end
        end
    end

`ifdef LS_BUFFER_PERF_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_load_cnt  <= '0;
            perf_store_cnt <= '0;
        end else begin
            if (bc_fire)    perf_load_cnt  <= perf_load_cnt + 32'd1;
            if (store_done) perf_store_cnt <= perf_store_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: rtl/ls_buffer.sv
// In-order load/store queue: entry storage, operand snoop, store commit and load release.
// Optional perf counter ports appear with LS_BUFFER_PERF_EN.
module ls_buffer
    import ls_buffer_pkg::*;
#(
    parameter int LSB_SIZE = LSB_SIZE_DEF,
    parameter int ROB_ID_W = ROB_ID_W_DEF,
    parameter int REG_W    = REG_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    output logic                is_ls_buffer_full,
    input  logic                valid_from_issuer,
    input  logic [3:0]          op_from_issuer,
    input  logic [ROB_ID_W-1:0] dest_from_issuer,
    input  logic [ROB_ID_W-1:0] qj_from_issuer,
    input  logic [REG_W-1:0]    vj_from_issuer,
    input  logic [ROB_ID_W-1:0] qk_from_issuer,
    input  logic [REG_W-1:0]    vk_from_issuer,
    input  logic [REG_W-1:0]    imm_from_issuer,
    input  logic                reset_from_rob_bus,
    input  logic [ROB_ID_W-1:0] dest_from_rob_bus,
    input  logic                ls_select_from_rob_bus,
    input  logic [ROB_ID_W-1:0] dest_from_rss_bus,
    input  logic [REG_W-1:0]    value_from_rss_bus,
    output logic [ROB_ID_W-1:0] dest_to_lsb_bus,
    output logic [REG_W-1:0]    value_to_lsb_bus,
    output logic                mem_valid,
    output logic                mem_we,
    output logic [REG_W-1:0]    mem_addr,
    output logic [REG_W-1:0]    mem_wdata,
    output logic [1:0]          mem_len,
    input  logic                mem_done,
    input  logic [REG_W-1:0]    mem_rdata
`ifdef LS_BUFFER_PERF_EN
    ,
    output logic [31:0]         perf_load_cnt,
    output logic [31:0]         perf_store_cnt
`endif
);
    localparam int IDX_W = $clog2(LSB_SIZE);

    logic [LSB_SIZE-1:0] e_valid, e_committed, flush_keep;
    logic [3:0]          e_op   [LSB_SIZE];
    logic [ROB_ID_W-1:0] e_dest [LSB_SIZE];
    logic [ROB_ID_W-1:0] e_qj   [LSB_SIZE];
    logic [ROB_ID_W-1:0] e_qk   [LSB_SIZE];
    logic [REG_W-1:0]    e_vj   [LSB_SIZE];
    logic [REG_W-1:0]    e_vk   [LSB_SIZE];
    logic [REG_W-1:0]    e_imm  [LSB_SIZE];

    logic [IDX_W-1:0]    head, tail, commit_idx;
    logic [IDX_W:0]      size, commit_cnt;
    logic                load_go, flush, enq, pop;
    logic                store_commit, load_release, head_store, head_ready;
    logic [ROB_ID_W-1:0] enq_qj, enq_qk;
    logic [REG_W-1:0]    enq_vj, enq_vk;

    assign flush      = reset_from_rob_bus;
    assign enq        = valid_from_issuer && !flush;
    assign commit_idx = head + commit_cnt[IDX_W-1:0];
    assign head_store = op_is_store(e_op[head]);

    assign is_ls_buffer_full = (size >= (IDX_W+1)'(LSB_SIZE-1));

    // committed stores always form a prefix starting at head
    assign store_commit = !flush && ls_select_from_rob_bus && (dest_from_rob_bus != '0)
                       && e_valid[commit_idx] && !e_committed[commit_idx]
                       && op_is_store(e_op[commit_idx])
                       && (e_dest[commit_idx] == dest_from_rob_bus);

    assign load_release = !flush && !ls_select_from_rob_bus && (dest_from_rob_bus != '0)
                       && e_valid[head] && !head_store && (e_dest[head] == dest_from_rob_bus);

    assign head_ready = e_valid[head] && (head_store
                      ? (e_committed[head] && e_qj[head] == '0 && e_qk[head] == '0)
                      : (load_go && e_qj[head] == '0 && !flush));

    always_comb begin
        flush_keep = '0;
        for (int i = 0; i < LSB_SIZE; i++)
            flush_keep[i] = ({1'b0, IDX_W'(i) - head} < commit_cnt);
    end

    // same-cycle bus hits are captured on the way in
    always_comb begin
        enq_qj = qj_from_issuer;
        enq_vj = vj_from_issuer;
        enq_qk = qk_from_issuer;
        enq_vk = vk_from_issuer;
        if (qj_from_issuer != '0) begin
            if (qj_from_issuer == dest_from_rss_bus) begin
                enq_qj = '0;
                enq_vj = value_from_rss_bus;
            end else if (qj_from_issuer == dest_to_lsb_bus) begin
                enq_qj = '0;
                enq_vj = value_to_lsb_bus;
            end
        end
        if (qk_from_issuer != '0) begin
            if (qk_from_issuer == dest_from_rss_bus) begin
                enq_qk = '0;
                enq_vk = value_from_rss_bus;
            end else if (qk_from_issuer == dest_to_lsb_bus) begin
                enq_qk = '0;
                enq_vk = value_to_lsb_bus;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head        <= '0;
            tail        <= '0;
            size        <= '0;
            commit_cnt  <= '0;
            load_go     <= 1'b0;
            e_valid     <= '0;
            e_committed <= '0;
        end else if (rdy) begin
            if (flush) begin
                e_valid     <= e_valid & flush_keep;
                e_committed <= e_committed & flush_keep;
            end
            if (store_commit) e_committed[commit_idx] <= 1'b1;
            if (pop) begin
                e_valid[head]     <= 1'b0;
                e_committed[head] <= 1'b0;
            end
            if (enq) begin
                e_valid[tail]     <= 1'b1;
                e_committed[tail] <= 1'b0;
            end
            head       <= head + IDX_W'(pop);
            tail       <= flush ? head + commit_cnt[IDX_W-1:0] : tail + IDX_W'(enq);
            size       <= flush ? commit_cnt - (IDX_W+1)'(pop)
                                : size + (IDX_W+1)'(enq) - (IDX_W+1)'(pop);
            commit_cnt <= commit_cnt + (IDX_W+1)'(store_commit) - (IDX_W+1)'(pop && head_store);
            if (flush || pop)      load_go <= 1'b0;
            else if (load_release) load_go <= 1'b1;
        end
    end

    // payload needs no reset: e_valid gates every use
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < LSB_SIZE; i++) begin
                if (e_valid[i] && e_qj[i] != '0) begin
                    if (e_qj[i] == dest_from_rss_bus) begin
                        e_qj[i] <= '0;
                        e_vj[i] <= value_from_rss_bus;
                    end else if (e_qj[i] == dest_to_lsb_bus) begin
                        e_qj[i] <= '0;
                        e_vj[i] <= value_to_lsb_bus;
                    end
                end
                if (e_valid[i] && e_qk[i] != '0) begin
                    if (e_qk[i] == dest_from_rss_bus) begin
                        e_qk[i] <= '0;
                        e_vk[i] <= value_from_rss_bus;
                    end else if (e_qk[i] == dest_to_lsb_bus) begin
                        e_qk[i] <= '0;
                        e_vk[i] <= value_to_lsb_bus;
                    end
                end
            end
            if (enq) begin
                e_op[tail]   <= op_from_issuer;
                e_dest[tail] <= dest_from_issuer;
                e_qj[tail]   <= enq_qj;
                e_vj[tail]   <= enq_vj;
                e_qk[tail]   <= enq_qk;
                e_vk[tail]   <= enq_vk;
                e_imm[tail]  <= imm_from_issuer;
            end
        end
    end

    ls_mem_unit #(.ROB_ID_W(ROB_ID_W), .REG_W(REG_W)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .req_valid (head_ready),
        .req_op    (e_op[head]),
        .req_dest  (e_dest[head]),
        .req_addr  (e_vj[head] + e_imm[head]),
        .req_wdata (e_vk[head]),
        .pop       (pop),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_len   (mem_len),
        .mem_done  (mem_done),
        .mem_rdata (mem_rdata),
        .bc_dest   (dest_to_lsb_bus),
        .bc_value  (value_to_lsb_bus)
`ifdef LS_BUFFER_PERF_EN
        ,
        .perf_load_cnt  (perf_load_cnt),
        .perf_store_cnt (perf_store_cnt)
`endif
    );
endmodule

// File: tb/tb_ls_buffer.sv
// Bench for ls_buffer: load extension table, store snoop/commit, flush and fill/drain sequences,
// with a scoreboard of expected lsb broadcasts.
module tb_ls_buffer;
    import ls_buffer_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rdy = 1'b1;
    logic        is_ls_buffer_full;
    logic        valid_from_issuer = 1'b0;
    logic [3:0]  op_from_issuer = '0;
    logic [3:0]  dest_from_issuer = '0, qj_from_issuer = '0, qk_from_issuer = '0;
    logic [31:0] vj_from_issuer = '0, vk_from_issuer = '0, imm_from_issuer = '0;
    logic        reset_from_rob_bus = 1'b0;
    logic [3:0]  dest_from_rob_bus = '0;
    logic        ls_select_from_rob_bus = 1'b0;
    logic [3:0]  dest_from_rss_bus = '0;
    logic [31:0] value_from_rss_bus = '0;
    logic [3:0]  dest_to_lsb_bus;
    logic [31:0] value_to_lsb_bus;
    logic        mem_valid, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [1:0]  mem_len;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;
`ifdef LS_BUFFER_PERF_EN
    logic [31:0] perf_load_cnt, perf_store_cnt;
`endif

    ls_buffer #(.LSB_SIZE(16), .ROB_ID_W(4), .REG_W(32)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .is_ls_buffer_full(is_ls_buffer_full),
        .valid_from_issuer(valid_from_issuer), .op_from_issuer(op_from_issuer),
        .dest_from_issuer(dest_from_issuer), .qj_from_issuer(qj_from_issuer),
        .vj_from_issuer(vj_from_issuer), .qk_from_issuer(qk_from_issuer),
        .vk_from_issuer(vk_from_issuer), .imm_from_issuer(imm_from_issuer),
        .reset_from_rob_bus(reset_from_rob_bus), .dest_from_rob_bus(dest_from_rob_bus),
        .ls_select_from_rob_bus(ls_select_from_rob_bus),
        .dest_from_rss_bus(dest_from_rss_bus), .value_from_rss_bus(value_from_rss_bus),
        .dest_to_lsb_bus(dest_to_lsb_bus), .value_to_lsb_bus(value_to_lsb_bus),
        .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata)
`ifdef LS_BUFFER_PERF_EN
        , .perf_load_cnt(perf_load_cnt), .perf_store_cnt(perf_store_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { logic [3:0] dest; logic [31:0] value; } bc_t;
    typedef struct {
        logic [3:0]  op;
        logic [31:0] vj, imm, rdata, addr;
        logic [1:0]  len;
        logic [31:0] exp;
    } vec_t;

    bc_t  sb[$];
    vec_t tv[8];
    int   n_tests = 0, n_fail = 0;
    int   n_ld = 0, n_st = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic issue(input logic [3:0] op, input logic [3:0] dest, input logic [3:0] qj,
                         input logic [31:0] vj, input logic [3:0] qk, input logic [31:0] vk,
                         input logic [31:0] imm);
        valid_from_issuer = 1'b1;
        op_from_issuer = op; dest_from_issuer = dest;
        qj_from_issuer = qj; vj_from_issuer = vj;
        qk_from_issuer = qk; vk_from_issuer = vk;
        imm_from_issuer = imm;
        tick();
        valid_from_issuer = 1'b0;
        qj_from_issuer = '0; qk_from_issuer = '0;
    endtask

    task automatic rob_commit(input logic [3:0] dest);
        dest_from_rob_bus = dest; ls_select_from_rob_bus = 1'b1;
        tick();
        dest_from_rob_bus = '0; ls_select_from_rob_bus = 1'b0;
    endtask

    task automatic wait_req(input string name, output bit ok);
        int n;
        n = 0;
        while (!mem_valid && n < 50) begin
            tick();
            n++;
        end
        ok = mem_valid;
        chk({name, " req_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic check_req(input string name, input logic we, input logic [31:0] addr,
                             input logic [1:0] len, input logic [31:0] wdata, input bit chk_wd);
        chk({name, " we"}, 32'(mem_we), 32'(we));
        chk({name, " addr"}, mem_addr, addr);
        chk({name, " len"}, 32'(mem_len), 32'(len));
        if (chk_wd) chk({name, " wdata"}, mem_wdata, wdata);
    endtask

    task automatic complete(input logic [31:0] rdata);
        mem_done = 1'b1; mem_rdata = rdata;
        tick();
        mem_done = 1'b0; mem_rdata = '0;
    endtask

    // scoreboard: every nonzero lsb dest must match the oldest expected broadcast
    always @(negedge clk) begin
        if (rst && dest_to_lsb_bus != '0) begin
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL lsb_unexpected: got dest %0d value %h expected no broadcast",
                         dest_to_lsb_bus, value_to_lsb_bus);
            end else begin
                bc_t e;
                e = sb.pop_front();
                if (dest_to_lsb_bus !== e.dest || value_to_lsb_bus !== e.value) begin
                    n_fail++;
                    $display("FAIL lsb_bcast: got dest %0d value %h expected dest %0d value %h",
                             dest_to_lsb_bus, value_to_lsb_bus, e.dest, e.value);
                end
            end
        end else if (rst && value_to_lsb_bus != '0) begin
            n_tests++;
            n_fail++;
            $display("FAIL lsb_idle_value: got %h expected 0", value_to_lsb_bus);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        tv[0] = '{OP_LW,  32'h100,      32'h4,        32'hDEADBEEF, 32'h104, 2'd2, 32'hDEADBEEF};
        tv[1] = '{OP_LB,  32'h200,      32'hFFFFFFFF, 32'h12345680, 32'h1FF, 2'd0, 32'hFFFFFF80};
        tv[2] = '{OP_LBU, 32'h200,      32'h0,        32'h12345680, 32'h200, 2'd0, 32'h00000080};
        tv[3] = '{OP_LH,  32'h10,       32'h2,        32'hABCD8001, 32'h12,  2'd1, 32'hFFFF8001};
        tv[4] = '{OP_LHU, 32'h10,       32'h2,        32'hABCD8001, 32'h12,  2'd1, 32'h00008001};
        tv[5] = '{OP_LH,  32'h20,       32'h0,        32'h00007FFF, 32'h20,  2'd1, 32'h00007FFF};
        tv[6] = '{OP_LW,  32'hFFFFFFFC, 32'h8,        32'h0BADF00D, 32'h4,   2'd2, 32'h0BADF00D};
        tv[7] = '{OP_LB,  32'h0,        32'h0,        32'hFFFFFF7F, 32'h0,   2'd0, 32'h0000007F};

        #2 rst = 1'b0;
        tick(3);
        chk("rst full", 32'(is_ls_buffer_full), 0);
        chk("rst mem_valid", 32'(mem_valid), 0);
        chk("rst mem_we", 32'(mem_we), 0);
        chk("rst mem_addr", mem_addr, 0);
        chk("rst mem_wdata", mem_wdata, 0);
        chk("rst mem_len", 32'(mem_len), 0);
        chk("rst lsb_dest", 32'(dest_to_lsb_bus), 0);
        chk("rst lsb_value", value_to_lsb_bus, 0);
        rst = 1'b1;
        tick(2);

        // loads: address, length and extension
        for (int i = 0; i < 8; i++) begin
            issue(tv[i].op, 4'(i + 1), 4'd0, tv[i].vj, 4'd0, 32'd0, tv[i].imm);
            dest_from_rob_bus = 4'(i + 1); ls_select_from_rob_bus = 1'b0;
            wait_req($sformatf("ld%0d", i), ok);
            if (ok) begin
                check_req($sformatf("ld%0d", i), 1'b0, tv[i].addr, tv[i].len, 32'd0, 1'b0);
                sb.push_back('{dest: 4'(i + 1), value: tv[i].exp});
                complete(tv[i].rdata);
                n_ld++;
            end
            dest_from_rob_bus = '0;
            tick(2);
        end

        // store data from rss bus, waits for commit
        issue(OP_SW, 4'd6, 4'd0, 32'h300, 4'd5, 32'd0, 32'h10);
        dest_from_rss_bus = 4'd5; value_from_rss_bus = 32'h1234;
        tick();
        dest_from_rss_bus = '0; value_from_rss_bus = '0;
        tick(3);
        chk("sw uncommitted idle", 32'(mem_valid), 0);
        rob_commit(4'd6);
        wait_req("sw", ok);
        if (ok) begin
            check_req("sw", 1'b1, 32'h310, 2'd2, 32'h1234, 1'b1);
            complete(32'hFFFFFFFF);
            n_st++;
        end
        tick(3);
        chk("sw done idle", 32'(mem_valid), 0);

        // store data captured from rss in the enqueue cycle
        dest_from_rss_bus = 4'd7; value_from_rss_bus = 32'hABCD;
        issue(OP_SH, 4'd8, 4'd0, 32'h40, 4'd7, 32'd0, 32'h2);
        dest_from_rss_bus = '0; value_from_rss_bus = '0;
        rob_commit(4'd8);
        wait_req("sh", ok);
        if (ok) begin
            check_req("sh", 1'b1, 32'h42, 2'd1, 32'hABCD, 1'b1);
            complete(32'h0);
            n_st++;
        end
        tick(2);

        // store data forwarded from this block's own load broadcast
        issue(OP_LW, 4'd9, 4'd0, 32'h80, 4'd0, 32'd0, 32'h0);
        issue(OP_SW, 4'd10, 4'd0, 32'h400, 4'd9, 32'd0, 32'h8);
        dest_from_rob_bus = 4'd9; ls_select_from_rob_bus = 1'b0;
        wait_req("lw9", ok);
        if (ok) begin
            check_req("lw9", 1'b0, 32'h80, 2'd2, 32'd0, 1'b0);
            sb.push_back('{dest: 4'd9, value: 32'h55AA});
            complete(32'h55AA);
            n_ld++;
        end
        dest_from_rob_bus = '0;
        tick(2);
        rob_commit(4'd10);
        wait_req("sw10", ok);
        if (ok) begin
            check_req("sw10", 1'b1, 32'h408, 2'd2, 32'h55AA, 1'b1);
            complete(32'h0);
            n_st++;
        end
        tick(2);

        // flush keeps committed store, drops uncommitted load
        issue(OP_SW, 4'd11, 4'd0, 32'h500, 4'd0, 32'h77, 32'h0);
        issue(OP_LW, 4'd12, 4'd0, 32'h600, 4'd0, 32'd0, 32'h0);
        rob_commit(4'd11);
        reset_from_rob_bus = 1'b1;
        tick();
        reset_from_rob_bus = 1'b0;
        wait_req("sw11", ok);
        if (ok) begin
            check_req("sw11", 1'b1, 32'h500, 2'd2, 32'h77, 1'b1);
            complete(32'h0);
            n_st++;
        end
        dest_from_rob_bus = 4'd12; ls_select_from_rob_bus = 1'b0;
        tick(10);
        chk("flushed load gone", 32'(mem_valid), 0);
        dest_from_rob_bus = '0;
        tick();

        // flush during load access: drain without broadcast
        issue(OP_LW, 4'd13, 4'd0, 32'h700, 4'd0, 32'd0, 32'h0);
        dest_from_rob_bus = 4'd13; ls_select_from_rob_bus = 1'b0;
        wait_req("lw13", ok);
        if (ok) check_req("lw13", 1'b0, 32'h700, 2'd2, 32'd0, 1'b0);
        reset_from_rob_bus = 1'b1; dest_from_rob_bus = '0;
        tick();
        reset_from_rob_bus = 1'b0;
        tick(3);
        chk("drain holds valid", 32'(mem_valid), 1);
        complete(32'h99);
        tick(2);
        chk("drain done", 32'(mem_valid), 0);

        // next load runs normally; rdy low freezes the request
        issue(OP_LH, 4'd14, 4'd0, 32'h800, 4'd0, 32'd0, 32'h6);
        dest_from_rob_bus = 4'd14; ls_select_from_rob_bus = 1'b0;
        wait_req("lh14", ok);
        if (ok) begin
            check_req("lh14", 1'b0, 32'h806, 2'd1, 32'd0, 1'b0);
            rdy = 1'b0;
            tick(3);
            chk("rdy0 valid held", 32'(mem_valid), 1);
            chk("rdy0 addr held", mem_addr, 32'h806);
            rdy = 1'b1;
            sb.push_back('{dest: 4'd14, value: 32'hFFFF8000});
            complete(32'h8000);
            n_ld++;
        end
        dest_from_rob_bus = '0;
        tick(2);

        // fill to pre-full across the index wrap, then drain in order
        chk("fill empty", 32'(is_ls_buffer_full), 0);
        for (int k = 1; k <= 15; k++) begin
            issue(OP_LW, 4'(k), 4'd0, 32'h1000 + 32'(k * 16), 4'd0, 32'd0, 32'h0);
            if (k == 14) chk("fill 14 not full", 32'(is_ls_buffer_full), 0);
        end
        chk("fill 15 full", 32'(is_ls_buffer_full), 1);
        for (int k = 1; k <= 15; k++) begin
            dest_from_rob_bus = 4'(k); ls_select_from_rob_bus = 1'b0;
            wait_req($sformatf("drain%0d", k), ok);
            if (ok) begin
                check_req($sformatf("drain%0d", k), 1'b0, 32'h1000 + 32'(k * 16), 2'd2, 32'd0, 1'b0);
                sb.push_back('{dest: 4'(k), value: 32'hA000 + 32'(k)});
                complete(32'hA000 + 32'(k));
                n_ld++;
                if (k == 1) chk("full deasserts", 32'(is_ls_buffer_full), 0);
            end
            dest_from_rob_bus = '0;
            tick();
        end
        tick(3);
        chk("drain idle", 32'(mem_valid), 0);
        chk("scoreboard empty", 32'(sb.size()), 0);
`ifdef LS_BUFFER_PERF_EN
        chk("perf loads", perf_load_cnt, 32'(n_ld));
        chk("perf stores", perf_store_cnt, 32'(n_st));
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
